// File: rtl/bchg_pkg.sv
// Shared types and defaults for the battery-charger comparator sense filter.
package bchg_pkg;

    typedef enum logic [1:0] {
        CH_VTRKL  = 2'd0,
        CH_VTERM  = 2'd1,
        CH_ITERM  = 2'd2,
        CH_VRCHRG = 2'd3
    } bchg_ch_e;

    localparam int BCHG_NCH    = 4;
    localparam int PRESC_DEF   = 16;
    localparam int DEB_CNT_DEF = 4;
    localparam int BLANK_DEF   = 8;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bchg_debounce.sv
// One comparator channel: 2-flop synchronizer followed by a tick-sampled
// debounce counter that flips the output after DEB_CNT mismatching ticks.
module bchg_debounce
    import bchg_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic hold,
    input  logic din,
    output logic dout
);

    localparam int CW = cnt_width(DEB_CNT + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

    logic          sync_1;
    logic          s_x;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            s_x    <= 1'b0;
        end else begin
            sync_1 <= din;
            s_x    <= sync_1;
        end
    end

    // hold wins over everything so a blanked channel restarts from a clean count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (hold) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (tick) begin
            if (s_x != dout) begin
                if (cnt == LAST) begin
                    dout <= ~dout;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bchg_sense_filter.sv
// Charger comparator front end: prescaled tick, four debounced channels, valid flag.
// Optional iterm blanking after a vterm rise is built when BCHG_SENSE_ITERM_BLANK_EN is defined.
module bchg_sense_filter
    import bchg_pkg::*;
#(
    parameter int PRESC   = PRESC_DEF,
    parameter int DEB_CNT = DEB_CNT_DEF,
    parameter int BLANK   = BLANK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic cmp_vtrkl,
    input  logic cmp_vterm,
    input  logic cmp_iterm,
    input  logic cmp_vrchrg,
    output logic vtrkl,
    output logic vterm,
    output logic iterm,
    output logic vrchrg,
    output logic valid,
    output logic tick
);

    localparam int PW = cnt_width(PRESC);
    localparam int VW = cnt_width(DEB_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0]       presc_cnt;
    logic [VW-1:0]       tick_cnt;
    logic [BCHG_NCH-1:0] cmp_vec;
    logic [BCHG_NCH-1:0] out_vec;
    logic [BCHG_NCH-1:0] hold_vec;

    assign cmp_vec = {cmp_vrchrg, cmp_iterm, cmp_vterm, cmp_vtrkl};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (presc_cnt == PRESC_LAST) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Gated by reset so PRESC=1 still shows tick low while in reset.
    assign tick = (presc_cnt == PRESC_LAST) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            valid    <= 1'b0;
        end else if (tick) begin
            if (tick_cnt != VW'(DEB_CNT)) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (tick_cnt == VW'(DEB_CNT - 1)) begin
                valid <= 1'b1;
            end
        end
    end

`ifdef BCHG_SENSE_ITERM_BLANK_EN
    localparam int BW = cnt_width(BLANK + 1);

    logic [BW-1:0] blank_cnt;
    logic          vterm_d;
    logic          vterm_rise;

    // The rise is seen the cycle after it lands; vterm_rise covers that cycle.
    assign vterm_rise = out_vec[CH_VTERM] && !vterm_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vterm_d   <= 1'b0;
            blank_cnt <= '0;
        end else begin
            vterm_d <= out_vec[CH_VTERM];
            if (vterm_rise) begin
                blank_cnt <= BW'(BLANK);
            end else if (tick && (blank_cnt != '0)) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        hold_vec           = '0;
        hold_vec[CH_ITERM] = vterm_rise || (blank_cnt != '0);
    end
`else
    logic unused_blank;

    assign unused_blank = (BLANK > 0);
    assign hold_vec     = '0;
`endif

    for (genvar i = 0; i < BCHG_NCH; i++) begin : g_ch
        localparam bchg_ch_e CH = bchg_ch_e'(i);

        bchg_debounce #(
            .DEB_CNT(DEB_CNT)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .hold (hold_vec[CH]),
            .din  (cmp_vec[CH]),
            .dout (out_vec[CH])
        );
    end

    assign vtrkl  = out_vec[CH_VTRKL];
    assign vterm  = out_vec[CH_VTERM];
    assign iterm  = out_vec[CH_ITERM];
    assign vrchrg = out_vec[CH_VRCHRG];

endmodule

// File: tb/tb_bchg_sense_filter.sv
// Directed bench for bchg_sense_filter with PRESC=4, DEB_CNT=3, BLANK=5.
module tb_bchg_sense_filter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmp_vtrkl = 1'b0;
    logic cmp_vterm = 1'b0;
    logic cmp_iterm = 1'b0;
    logic cmp_vrchrg = 1'b0;
    logic vtrkl, vterm, iterm, vrchrg, valid, tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bchg_sense_filter #(
        .PRESC  (4),
        .DEB_CNT(3),
        .BLANK  (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmp_vtrkl (cmp_vtrkl),
        .cmp_vterm (cmp_vterm),
        .cmp_iterm (cmp_iterm),
        .cmp_vrchrg(cmp_vrchrg),
        .vtrkl     (vtrkl),
        .vterm     (vterm),
        .iterm     (iterm),
        .vrchrg    (vrchrg),
        .valid     (valid),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic t, input logic v, input logic i, input logic r);
        cmp_vtrkl  = t;
        cmp_vterm  = v;
        cmp_iterm  = i;
        cmp_vrchrg = r;
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to 1ns after posedge number n counted from the last reset release.
    task automatic stepTo(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_vtrkl", vtrkl, 1'b0);
        checkOutput("rst_vterm", vterm, 1'b0);
        checkOutput("rst_iterm", iterm, 1'b0);
        checkOutput("rst_vrchrg", vrchrg, 1'b0);
        checkOutput("rst_valid", valid, 1'b0);
        checkOutput("rst_tick", tick, 1'b0);

        releaseReset();
        stepTo(2);
        checkOutput("tick_c3", tick, 1'b0);
        stepTo(3);
        checkOutput("tick_c4", tick, 1'b1);
        stepTo(4);
        checkOutput("tick_c5", tick, 1'b0);
        stepTo(7);
        checkOutput("tick_c8", tick, 1'b1);
        stepTo(11);
        checkOutput("valid_e11", valid, 1'b0);
        stepTo(12);
        checkOutput("valid_e12", valid, 1'b1);
        checkOutput("idle_vtrkl", vtrkl, 1'b0);
        checkOutput("idle_iterm", iterm, 1'b0);

        stepTo(20);
        checkOutput("valid_sticky", valid, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepTo(28);
        checkOutput("rise_vtrkl_t2", vtrkl, 1'b0);
        stepTo(31);
        checkOutput("rise_vtrkl_pre", vtrkl, 1'b0);
        stepTo(32);
        checkOutput("rise_vtrkl", vtrkl, 1'b1);
        checkOutput("rise_vterm_q", vterm, 1'b0);
        checkOutput("rise_iterm_q", iterm, 1'b0);
        checkOutput("rise_vrchrg_q", vrchrg, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepTo(40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepTo(44);
        checkOutput("glitch_vterm_t44", vterm, 1'b0);
        stepTo(48);
        checkOutput("glitch_vterm_t48", vterm, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepTo(56);
        checkOutput("fresh_vterm_t2", vterm, 1'b0);
        stepTo(59);
        checkOutput("fresh_vterm_pre", vterm, 1'b0);
        stepTo(60);
        checkOutput("fresh_vterm", vterm, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        stepTo(72);
        checkOutput("set_vrchrg", vrchrg, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepTo(83);
        checkOutput("fall_vrchrg_pre", vrchrg, 1'b1);
        stepTo(84);
        checkOutput("fall_vrchrg", vrchrg, 1'b0);
        checkOutput("fall_vtrkl_q", vtrkl, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepTo(92);
        checkOutput("mid_vtrkl_held", vtrkl, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_vtrkl", vtrkl, 1'b0);
        checkOutput("mid_rst_vterm", vterm, 1'b0);
        checkOutput("mid_rst_valid", valid, 1'b0);
        checkOutput("mid_rst_tick", tick, 1'b0);

        releaseReset();
        stepTo(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepTo(8);
        checkOutput("rel_vterm_t2", vterm, 1'b0);
        stepTo(11);
        checkOutput("rel_vterm_pre", vterm, 1'b0);
        checkOutput("rel_valid_pre", valid, 1'b0);
        stepTo(12);
        checkOutput("rel_vterm", vterm, 1'b1);
        checkOutput("rel_valid", valid, 1'b1);
        checkOutput("rel_vtrkl", vtrkl, 1'b0);
        stepTo(15);
        checkOutput("blank_iterm_pre", iterm, 1'b0);
        stepTo(16);
`ifdef BCHG_SENSE_ITERM_BLANK_EN
        checkOutput("blank_iterm_t16", iterm, 1'b0);
        stepTo(32);
        checkOutput("blank_iterm_t32", iterm, 1'b0);
        stepTo(43);
        checkOutput("blank_iterm_pre_rise", iterm, 1'b0);
        stepTo(44);
        checkOutput("blank_iterm_rise", iterm, 1'b1);
`else
        checkOutput("noblank_iterm", iterm, 1'b1);
        stepTo(32);
        checkOutput("noblank_iterm_hold", iterm, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bchg_sense_filter.md
# bchg_sense_filter

Digital front end for the battery-charger controller. It takes the four raw analog comparator outputs (trickle threshold, termination voltage, termination current, recharge threshold), synchronizes them to `clk`, and debounces each on a prescaled sample tick. It drives the clean `vtrkl`, `vterm`, `iterm` and `vrchrg` level inputs of the charger state machine directly downstream. A `valid` flag tells the system when the first full debounce window has completed.

## Interface
Parameters:
- `PRESC`, 16: clk cycles per sample tick; legal values ≥ 1 (1 = a tick every cycle).
- `DEB_CNT`, 4: consecutive mismatching ticks required to flip an output; legal values ≥ 1.
- `BLANK`, 8: iterm blanking length in ticks. Used only with `BCHG_SENSE_ITERM_BLANK_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `cmp_vtrkl`, `cmp_vterm`, `cmp_iterm`, `cmp_vrchrg`  in  1 each  raw comparator outputs; asynchronous to `clk`.
- `vtrkl`, `vterm`, `iterm`, `vrchrg`  out  1 each  debounced levels, registered.
- `valid`  out  1  high once the first debounce window after reset has completed; sticky until reset.
- `tick`  out  1  single-cycle sample strobe, exported for observation.

## Operation
- **Synchronizer:** each `cmp_*` input passes through a 2-flop synchronizer; the second flop is called `s_*`.
- **Prescaler:**
  - Counter of width `$clog2(PRESC)` (minimum 1 bit) counts 0..`PRESC`-1 and wraps.
  - `tick`=1 in the cycle the count equals `PRESC`-1.
- **Per-channel debounce:** a `$clog2(DEB_CNT+1)`-bit counter and the output register.
  - On a tick with `s_x` ≠ `x`: if the counter = `DEB_CNT`-1, flip `x` and clear the counter; otherwise increment.
  - On a tick with `s_x` == `x`: clear the counter.
  - No tick: hold.
  - Net effect: a glitch shorter than `DEB_CNT` consecutive ticks never reaches the output.
- **Valid:**
  - A tick counter saturates at `DEB_CNT`.
  - `valid` is registered high on the `DEB_CNT`-th tick after reset release, in the same edge that any initial flips land.
  - `valid` never falls except on reset.
- **Channel independence:** all four channels run independently. Simultaneous flips on several channels in the same tick are allowed.
- **Reset:**
  - All outputs are 0: `vtrkl`=`vterm`=`iterm`=`vrchrg`=0, `valid`=0, `tick`=0.
  - All counters and synchronizer flops are 0.
  - Reset mid-count discards the partial count immediately, because the reset is asynchronous.

## Timing
- Input edge to synchronized value: 2 clk.
- Synchronized edge to output flip: `DEB_CNT` ticks, i.e. from (`DEB_CNT`-1)·`PRESC`+1 to `DEB_CNT`·`PRESC` clk, depending on prescaler phase.
- Outputs change only on the clk edge that ends a tick cycle.
- `valid` rises at clk edge `DEB_CNT`·`PRESC` after reset release.
- `tick` first asserts in cycle `PRESC` (1-based) after reset release.

## Configuration
- Macro: `BCHG_SENSE_ITERM_BLANK_EN`.
- **Defined:**
  - A blank counter loads `BLANK` on the edge where the filtered `vterm` rises 0→1.
  - The counter decrements on each tick while nonzero.
  - While the counter is nonzero, `iterm` is forced 0 and the iterm debounce counter is held at 0.
  - A new `vterm` rise during blanking reloads `BLANK`.
  - Purpose: masks the current transient at entry to constant-voltage charging.
- **Undefined:** no blanking logic is generated, `BLANK` is ignored, and `iterm` is filtered like the other channels.

## Structure
- **Package `bchg_pkg`:**
  - Channel index enum `bchg_ch_e` (`CH_VTRKL`, `CH_VTERM`, `CH_ITERM`, `CH_VRCHRG`).
  - `BCHG_NCH`=4.
  - Default `PRESC`/`DEB_CNT`/`BLANK` constants.
- **Sub-module `bchg_debounce`:**
  - One channel: synchronizer, counter and output register.
  - Ports: `clk`, `reset`, `tick`, `hold`, `din`, `dout`.
  - Instantiated 4× via generate over `bchg_ch_e`.
  - `hold` is tied 0 except for iterm when blanking is enabled.

## Test plan
All scenarios use `PRESC`=4, `DEB_CNT`=3, `BLANK`=5.
- **Reset, inputs 0:** release reset with all `cmp_*`=0 → all outputs 0; `tick` every 4th clk; `valid` rises at clk 12 and stays high.
- **Rising step:** `cmp_vtrkl` 0→1, held → `vtrkl` stays 0 for the first 2 mismatching ticks and rises on the 3rd; no other output changes.
- **Glitch rejection:** `cmp_vterm` high for 2 ticks, then low → `vterm` remains 0; a fresh high then needs a full 3 ticks to set it.
- **Falling step:** `vrchrg`=1, `cmp_vrchrg` 1→0 → `vrchrg` falls on the 3rd tick after synchronization.
- **Reset mid-count:** assert `reset` after 2 mismatching ticks → outputs and `valid` are 0 within the same cycle; after release, 3 new ticks are needed.
- **Blanking:** `vterm` rises while `cmp_iterm`=1 → with the macro, `iterm` stays 0 for 5 ticks then rises 3 ticks later; without the macro, it rises after 3 ticks.
